// File: rtl/hsfsm_grant_sequencer.sv
// Master FSM with round-robin dwell-slot arbitration between two units.
// All outputs are registered; substates derive from next-state values.
module hsfsm_grant_sequencer #(
  parameter int DWELL   = 16,
  parameter int TIMEOUT = 64,
  parameter int CTR_W   = 8
) (
  input  logic             sysclk,
  input  logic             sysrst_n,
  input  logic [1:0]       req,
  input  logic             hold,
  input  logic             err_clr,
  output logic [1:0]       gnt,
  output logic [1:0]       sus1,
  output logic [1:0]       sus2,
  output logic [1:0]       master_state,
  output logic [CTR_W-1:0] event_ctr
);

  localparam int DW = $clog2(DWELL);
  localparam int SW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DW_END = DW'(DWELL - 1);
  localparam logic [SW-1:0] SW_END = SW'(TIMEOUT - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_ERR   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             rr_q, rr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       sus1_q, sus1_d;
  logic [1:0]       sus2_q, sus2_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [1:0]       win;
  logic             issue;
  logic             slot_end;

  // rr_q=1 means unit2 was granted last, so unit1 wins a tie
  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = rr_q ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  assign slot_end = (dwell_q == DW_END) ||
                    ((gnt_q & req) == 2'b00);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    stall_d = stall_q;
    gnt_d   = gnt_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (hold) begin
          state_d = S_STALL;
          stall_d = '0;
        end else if (|req) begin
          state_d = S_RUN;
          gnt_d   = win;
          dwell_d = '0;
          issue   = 1'b1;
        end
      end
      S_RUN: begin
        if (hold) begin
          state_d = S_STALL;
          gnt_d   = 2'b00;
          stall_d = '0;
        end else if (slot_end) begin
          if (|req) begin
            gnt_d   = win;
            dwell_d = '0;
            issue   = 1'b1;
          end else begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_STALL: begin
        gnt_d = 2'b00;
        if (!hold) begin
          state_d = S_IDLE;
        end else if (stall_q == SW_END) begin
          state_d = S_ERR;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      S_ERR: begin
        gnt_d = 2'b00;
        if (err_clr) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    rr_d  = rr_q;
    ctr_d = ctr_q;
    if (issue) begin
      rr_d = gnt_d[1];
      if (ctr_q != CTR_MAX) ctr_d = ctr_q + 1'b1;
    end
  end

  always_comb begin
    sus1_d = 2'b00;
    sus2_d = 2'b00;
    if (state_d != S_ERR) begin
      if (gnt_d[0])    sus1_d = 2'b10;
      else if (req[0]) sus1_d = 2'b01;
      if (gnt_d[1])    sus2_d = 2'b10;
      else if (req[1]) sus2_d = 2'b01;
    end
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      stall_q <= '0;
      rr_q    <= 1'b1;
      gnt_q   <= 2'b00;
      sus1_q  <= 2'b00;
      sus2_q  <= 2'b00;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      stall_q <= stall_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      sus1_q  <= sus1_d;
      sus2_q  <= sus2_d;
      ctr_q   <= ctr_d;
    end
  end

  assign gnt          = gnt_q;
  assign sus1         = sus1_q;
  assign sus2         = sus2_q;
  assign master_state = state_q;
  assign event_ctr    = ctr_q;

endmodule

// File: tb/tb_hsfsm_grant_sequencer.sv
// Directed vector table plus hand-written saturation and async-reset
// sequences for hsfsm_grant_sequencer at DWELL=16, TIMEOUT=64, CTR_W=8.
module tb_hsfsm_grant_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       hold;
  logic       err_clr;
  logic [1:0] gnt;
  logic [1:0] sus1;
  logic [1:0] sus2;
  logic [1:0] ms;
  logic [7:0] ctr;

  int n_run;
  int n_fail;

  hsfsm_grant_sequencer #(
    .DWELL(16),
    .TIMEOUT(64),
    .CTR_W(8)
  ) dut (
    .sysclk(clk),
    .sysrst_n(rst_n),
    .req(req),
    .hold(hold),
    .err_clr(err_clr),
    .gnt(gnt),
    .sus1(sus1),
    .sus2(sus2),
    .master_state(ms),
    .event_ctr(ctr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] req;
    logic       hold;
    logic       clr;
    int         ncyc;
    logic [1:0] gnt;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] ms;
    logic [7:0] ctr;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [1:0] eg,
                       input logic [1:0] e1,
                       input logic [1:0] e2,
                       input logic [1:0] em,
                       input logic [7:0] ec);
    logic [15:0] act, exp;
    act = {gnt, sus1, sus2, ms, ctr};
    exp = {eg, e1, e2, em, ec};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b s1=%b s2=%b ms=%b ctr=%0d, want gnt=%b s1=%b s2=%b ms=%b ctr=%0d",
               nm, gnt, sus1, sus2, ms, ctr, eg, e1, e2, em, ec);
    end
  endtask

  function automatic vec_t mk(string nm, logic [1:0] r, logic h,
                              logic c, int n, logic [1:0] g,
                              logic [1:0] a, logic [1:0] b,
                              logic [1:0] m, logic [7:0] k);
    vec_t v;
    v.name = nm; v.req = r; v.hold = h; v.clr = c; v.ncyc = n;
    v.gnt = g; v.s1 = a; v.s2 = b; v.ms = m; v.ctr = k;
    return v;
  endfunction

  initial begin
    n_run   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 2'b00;
    hold    = 1'b0;
    err_clr = 1'b0;

    //            name           req   h  c  n   gnt  s1   s2   ms   ctr
    tbl.push_back(mk("idle",     2'b00,0,0, 1, 2'b00,2'b00,2'b00,2'b00,8'd0));
    tbl.push_back(mk("t1_gnt",   2'b01,0,0, 1, 2'b01,2'b10,2'b00,2'b01,8'd1));
    tbl.push_back(mk("t1_dwell", 2'b01,0,0,15, 2'b01,2'b10,2'b00,2'b01,8'd1));
    tbl.push_back(mk("t1_regnt", 2'b01,0,0, 1, 2'b01,2'b10,2'b00,2'b01,8'd2));
    tbl.push_back(mk("t2_think", 2'b11,0,0, 1, 2'b01,2'b10,2'b01,2'b01,8'd2));
    tbl.push_back(mk("t2_pre",   2'b11,0,0,14, 2'b01,2'b10,2'b01,2'b01,8'd2));
    tbl.push_back(mk("t2_sw2",   2'b11,0,0, 1, 2'b10,2'b01,2'b10,2'b01,8'd3));
    tbl.push_back(mk("t2_sw1",   2'b11,0,0,16, 2'b01,2'b10,2'b01,2'b01,8'd4));
    tbl.push_back(mk("t3_mid",   2'b11,0,0, 5, 2'b01,2'b10,2'b01,2'b01,8'd4));
    tbl.push_back(mk("t3_drop",  2'b10,0,0, 1, 2'b10,2'b00,2'b10,2'b01,8'd5));
    tbl.push_back(mk("t4_stall", 2'b10,1,0, 1, 2'b00,2'b00,2'b01,2'b10,8'd5));
    tbl.push_back(mk("t4_hold",  2'b10,1,0, 9, 2'b00,2'b00,2'b01,2'b10,8'd5));
    tbl.push_back(mk("t4_idle",  2'b10,0,0, 1, 2'b00,2'b00,2'b01,2'b00,8'd5));
    tbl.push_back(mk("t4_run",   2'b10,0,0, 1, 2'b10,2'b00,2'b10,2'b01,8'd6));
    tbl.push_back(mk("t5_stall", 2'b11,1,0, 1, 2'b00,2'b01,2'b01,2'b10,8'd6));
    tbl.push_back(mk("t5_63",    2'b11,1,0,63, 2'b00,2'b01,2'b01,2'b10,8'd6));
    tbl.push_back(mk("t5_err",   2'b11,1,0, 1, 2'b00,2'b00,2'b00,2'b11,8'd6));
    tbl.push_back(mk("t5_ign",   2'b11,0,0, 3, 2'b00,2'b00,2'b00,2'b11,8'd6));
    tbl.push_back(mk("t5_clr",   2'b11,0,1, 1, 2'b00,2'b01,2'b01,2'b00,8'd6));
    tbl.push_back(mk("t5_rr",    2'b11,0,0, 1, 2'b01,2'b10,2'b01,2'b01,8'd7));
    tbl.push_back(mk("drop_idl", 2'b00,0,0, 1, 2'b00,2'b00,2'b00,2'b00,8'd7));
    tbl.push_back(mk("hold_pri", 2'b01,1,0, 1, 2'b00,2'b01,2'b00,2'b10,8'd7));
    tbl.push_back(mk("unstall",  2'b00,0,0, 1, 2'b00,2'b00,2'b00,2'b00,8'd7));

    step(2);
    check("reset", 2'b00, 2'b00, 2'b00, 2'b00, 8'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req     = tbl[i].req;
      hold    = tbl[i].hold;
      err_clr = tbl[i].clr;
      step(tbl[i].ncyc);
      check(tbl[i].name, tbl[i].gnt, tbl[i].s1, tbl[i].s2,
            tbl[i].ms, tbl[i].ctr);
    end

    // 248 more grants at 16 cycles each saturate the counter at 255
    req     = 2'b01;
    hold    = 1'b0;
    err_clr = 1'b0;
    step(4200);
    check("sat", 2'b01, 2'b10, 2'b00, 2'b01, 8'd255);
    step(40);
    check("sat_hold", 2'b01, 2'b10, 2'b00, 2'b01, 8'd255);

    // asynchronous reset between clock edges, mid-slot
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 2'b00, 2'b00, 2'b00, 2'b00, 8'd0);
    step(1);
    req = 2'b11;
    rst_n = 1'b1;
    step(1);
    check("post_rst", 2'b01, 2'b10, 2'b01, 2'b01, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
